// File: rtl/nibble_serial_adder.sv
// rtl/nibble_serial_adder.sv - WIDTH-bit adder that adds one nibble per clock through a shared 4-bit lookahead slice
//
// Purpose:
//   Accepts a, b, c_in over a valid/ready handshake. It then adds one nibble
//   per clock, least significant nibble first. The carry is registered
//   between nibbles. The finished {c_out, sum} is presented over a second
//   valid/ready handshake.
//   Optional feature macro: SIGNED_OVF_EN. When it is defined, the ovf port
//   and the signed-overflow flag are present.
//
// Ports:
//   clk        in   1      clock; all state updates on the rising edge
//   rst        in   1      synchronous active-high reset
//   in_valid   in   1      a, b, c_in are valid
//   in_ready   out  1      operands can be accepted (IDLE only)
//   a, b       in   WIDTH  operands
//   c_in       in   1      carry into nibble 0
//   out_valid  out  1      sum, c_out (and ovf) are valid (DONE only)
//   out_ready  in   1      consumer accepts the result
//   sum        out  WIDTH  registered sum, changes only when a result completes
//   c_out      out  1      carry out of the top nibble
//   ovf        out  1      signed overflow (SIGNED_OVF_EN only)

module nibble_serial_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out
`ifdef SIGNED_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int NIB   = WIDTH / 4;
  localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   partial_q, partial_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               carry_q, carry_d;
  logic               c_out_q, c_out_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
`ifdef SIGNED_OVF_EN
  logic               ovf_q, ovf_d;
`endif

  // Shared 4-bit carry-lookahead slice, fed by the nibble selected by idx_q.
  logic [3:0] a_nib, b_nib;
  logic [3:0] g, p, c;
  logic [3:0] s_nib;

  always_comb begin
    a_nib = a_q[idx_q*4 +: 4];
    b_nib = b_q[idx_q*4 +: 4];
    g     = a_nib & b_nib;
    p     = a_nib ^ b_nib;
    // Each carry is written in flattened lookahead form, so c[3] does not
    // ripple through c[0..2].
    c[0]  = g[0] | (p[0] & carry_q);
    c[1]  = g[1] | (p[1] & g[0]) | (p[1] & p[0] & carry_q);
    c[2]  = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
          | (p[2] & p[1] & p[0] & carry_q);
    c[3]  = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
          | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & carry_q);
    s_nib = p ^ {c[2:0], carry_q};
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    partial_d   = partial_q;
    sum_d       = sum_q;
    idx_d       = idx_q;
    carry_d     = carry_q;
    c_out_d     = c_out_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
`ifdef SIGNED_OVF_EN
    ovf_d       = ovf_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (in_valid && in_ready_q) begin
          a_d        = a;
          b_d        = b;
          carry_d    = c_in;
          idx_d      = '0;
          in_ready_d = 1'b0;
          state_d    = ST_RUN;
        end
      end

      ST_RUN: begin
        partial_d[idx_q*4 +: 4] = s_nib;
        carry_d                 = c[3];
        idx_d                   = idx_q + IDX_W'(1);
        if (idx_q == IDX_W'(NIB - 1)) begin
          // partial_d already holds the top nibble, so it is the complete sum.
          // Copying it into sum here means no partial result appears on sum.
          sum_d       = partial_d;
          c_out_d     = c[3];
          out_valid_d = 1'b1;
          state_d     = ST_DONE;
`ifdef SIGNED_OVF_EN
          ovf_d = (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                  (partial_d[WIDTH-1] != a_q[WIDTH-1]);
`endif
        end
      end

      ST_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = ST_IDLE;
        end
      end

      default: begin
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
        state_d     = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      partial_q   <= '0;
      sum_q       <= '0;
      idx_q       <= '0;
      carry_q     <= 1'b0;
      c_out_q     <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
`ifdef SIGNED_OVF_EN
      ovf_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      partial_q   <= partial_d;
      sum_q       <= sum_d;
      idx_q       <= idx_d;
      carry_q     <= carry_d;
      c_out_q     <= c_out_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
`ifdef SIGNED_OVF_EN
      ovf_q       <= ovf_d;
`endif
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign c_out     = c_out_q;
`ifdef SIGNED_OVF_EN
  assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_nibble_serial_adder.sv
// tb/tb_nibble_serial_adder.sv - self-checking bench for nibble_serial_adder (WIDTH=16)

module tb_nibble_serial_adder;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        c_in;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sum;
  logic        c_out;
`ifdef SIGNED_OVF_EN
  logic        ovf;
`endif

  int errors = 0;
  int checks = 0;

  nibble_serial_adder #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .c_in      (c_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .c_out     (c_out)
`ifdef SIGNED_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: {c_out, sum} is the exact 17-bit sum a + b + c_in.
  function automatic logic [16:0] ref_add(input logic [15:0] x, input logic [15:0] y,
                                          input logic ci);
    ref_add = {1'b0, x} + {1'b0, y} + {16'd0, ci};
  endfunction

  // Signed overflow: the operands have the same sign and the result sign differs.
  function automatic logic ref_ovf(input logic [15:0] x, input logic [15:0] y,
                                   input logic ci);
    logic [16:0] r;
    r = ref_add(x, y, ci);
    ref_ovf = (x[15] == y[15]) && (r[15] != x[15]);
  endfunction

  // Drives one operation from IDLE and collects what it observes.
  // Leaves the bench at a negedge. With hs=1 it also completes the output handshake.
  task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_v, input logic tci,
                        input bit hs, output int lat, output logic [15:0] rs,
                        output logic rco, output logic rov, output bit sum_moved,
                        output bit ready_bad);
    logic [15:0] prev;
    @(negedge clk);
    a = ta; b = tb_v; c_in = tci; in_valid = 1'b1; out_ready = 1'b0;
    prev = sum;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    a = 16'($urandom); b = 16'($urandom); c_in = 1'($urandom);
    lat = -1; sum_moved = 0; ready_bad = in_ready;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (out_valid) begin
        lat = i;
        break;
      end
      if (sum !== prev) sum_moved = 1;
      if (in_ready) ready_bad = 1;
    end
    rs = sum; rco = c_out;
`ifdef SIGNED_OVF_EN
    rov = ovf;
`else
    rov = 1'b0;
`endif
    if (hs) begin
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; c_in = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (sum !== 16'h0000) begin errors++; $display("FAIL reset_sum got=%h exp=0000", sum); end
    checks++; if (c_out !== 1'b0) begin errors++; $display("FAIL reset_c_out got=%b exp=0", c_out); end
    rst = 1'b0;
  endtask

  task automatic test_directed();
    logic [15:0] ta[3];
    logic [15:0] tb_v[3];
    logic        tci[3];
    int lat; logic [15:0] rs; logic rco, rov; bit moved, rbad;
    logic [16:0] e;
    ta[0] = 16'h1234; tb_v[0] = 16'h4321; tci[0] = 1'b0;
    ta[1] = 16'h00FF; tb_v[1] = 16'h0001; tci[1] = 1'b1;
    ta[2] = 16'hFFFF; tb_v[2] = 16'h0001; tci[2] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      run_op(ta[k], tb_v[k], tci[k], 1'b1, lat, rs, rco, rov, moved, rbad);
      e = ref_add(ta[k], tb_v[k], tci[k]);
      checks++; if (lat !== 4) begin errors++; $display("FAIL dir%0d_latency got=%0d exp=4", k, lat); end
      checks++; if (rs !== e[15:0]) begin errors++; $display("FAIL dir%0d_sum got=%h exp=%h", k, rs, e[15:0]); end
      checks++; if (rco !== e[16]) begin errors++; $display("FAIL dir%0d_c_out got=%b exp=%b", k, rco, e[16]); end
      checks++; if (moved !== 1'b0) begin errors++; $display("FAIL dir%0d_sum_stable_in_run got=%b exp=0", k, moved); end
      checks++; if (rbad !== 1'b0) begin errors++; $display("FAIL dir%0d_in_ready_in_run got=%b exp=0", k, rbad); end
      checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        errors++; $display("FAIL dir%0d_after_handshake got=%b%b exp=01", k, out_valid, in_ready);
      end
    end
  endtask

  task automatic test_backpressure();
    int lat; logic [15:0] rs; logic rco, rov; bit moved, rbad;
    run_op(16'h1234, 16'h4321, 1'b0, 1'b0, lat, rs, rco, rov, moved, rbad);
    checks++; if (rs !== 16'h5555) begin errors++; $display("FAIL bp_sum got=%h exp=5555", rs); end
    in_valid = 1'b1; a = 16'hAAAA; b = 16'h1111; c_in = 1'b1; out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_out_valid_held c%0d got=%b exp=1", i, out_valid); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready c%0d got=%b exp=0", i, in_ready); end
      checks++; if (sum !== 16'h5555 || c_out !== 1'b0) begin
        errors++; $display("FAIL bp_sum_held c%0d got=%h/%b exp=5555/0", i, sum, c_out);
      end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL bp_release got=%b%b exp=01", out_valid, in_ready);
    end
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_no_new_op c%0d got=%b exp=0", i, out_valid); end
    end
  endtask

  task automatic test_reset_abort();
    int lat; logic [15:0] rs; logic rco, rov; bit moved, rbad; bit seen;
    @(negedge clk);
    a = 16'h1234; b = 16'h4321; c_in = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL abort_run_flags got=%b%b exp=10", in_ready, out_valid);
    end
    checks++; if (sum !== 16'h0000 || c_out !== 1'b0) begin
      errors++; $display("FAIL abort_run_sum got=%h/%b exp=0000/0", sum, c_out);
    end
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (out_valid) seen = 1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL abort_run_no_out_valid got=%b exp=0", seen); end
    run_op(16'h0001, 16'h0001, 1'b0, 1'b1, lat, rs, rco, rov, moved, rbad);
    checks++; if (rs !== 16'h0002 || lat !== 4) begin
      errors++; $display("FAIL abort_next_op got=%h lat=%0d exp=0002 lat=4", rs, lat);
    end

    // Reset while DONE with a coincident output handshake.
    run_op(16'h00FF, 16'h0001, 1'b1, 1'b0, lat, rs, rco, rov, moved, rbad);
    out_ready = 1'b1; rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0; rst = 1'b0;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || sum !== 16'h0000) begin
      errors++; $display("FAIL abort_done got=%b%b/%h exp=01/0000", out_valid, in_ready, sum);
    end

    // Reset while IDLE with a coincident input handshake: the operands must be dropped.
    a = 16'h0F0F; b = 16'h0101; in_valid = 1'b1; rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; rst = 1'b0;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL abort_idle_accept got=%b exp=1", in_ready); end
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (out_valid) seen = 1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL abort_idle_no_out_valid got=%b exp=0", seen); end
  endtask

  task automatic test_random();
    int lat; logic [15:0] rs; logic rco, rov; bit moved, rbad;
    logic [15:0] ta, tb_v; logic tci; logic [16:0] e;
    for (int k = 0; k < 40; k++) begin
      ta = 16'($urandom); tb_v = 16'($urandom); tci = 1'($urandom);
      if (k == 0) begin ta = 16'hFFFF; tb_v = 16'hFFFF; tci = 1'b1; end
      run_op(ta, tb_v, tci, 1'b1, lat, rs, rco, rov, moved, rbad);
      e = ref_add(ta, tb_v, tci);
      checks++; if ({rco, rs} !== e || lat !== 4) begin
        errors++; $display("FAIL rand%0d %h+%h+%b got=%b_%h lat=%0d exp=%b_%h lat=4",
                           k, ta, tb_v, tci, rco, rs, lat, e[16], e[15:0]);
      end
`ifdef SIGNED_OVF_EN
      checks++; if (rov !== ref_ovf(ta, tb_v, tci)) begin
        errors++; $display("FAIL rand%0d_ovf got=%b exp=%b", k, rov, ref_ovf(ta, tb_v, tci));
      end
`endif
    end
  endtask

  task automatic test_back_to_back();
    logic [16:0] expq[$];
    logic [16:0] e;
    logic [15:0] ta, tb_v; logic tci;
    int t, last_t, got, sent;
    t = 0; last_t = -1; got = 0; sent = 0;
    @(negedge clk);
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 80 && got < 5; cyc++) begin
      if (out_valid) begin
        checks++;
        if (expq.size() == 0) begin
          errors++; $display("FAIL b2b_spurious_out got=%h exp=none", sum);
        end else begin
          e = expq.pop_front();
          if ({c_out, sum} !== e) begin
            errors++; $display("FAIL b2b_result%0d got=%b_%h exp=%b_%h", got, c_out, sum, e[16], e[15:0]);
          end
        end
        if (last_t >= 0) begin
          checks++; if (t - last_t !== 6) begin
            errors++; $display("FAIL b2b_interval got=%0d exp=6", t - last_t);
          end
        end
        last_t = t;
        got++;
      end
      if (in_ready && sent < 5) begin
        ta = 16'($urandom); tb_v = 16'($urandom); tci = 1'($urandom);
        a = ta; b = tb_v; c_in = tci; in_valid = 1'b1;
        expq.push_back(ref_add(ta, tb_v, tci));
        sent++;
      end else begin
        in_valid = (sent < 5);
        a = 16'($urandom); b = 16'($urandom); c_in = 1'($urandom);
      end
      @(posedge clk);
      @(negedge clk);
      t++;
    end
    in_valid = 1'b0; out_ready = 1'b0;
    checks++; if (got !== 5) begin errors++; $display("FAIL b2b_count got=%0d exp=5", got); end
  endtask

`ifdef SIGNED_OVF_EN
  task automatic test_signed_ovf();
    int lat; logic [15:0] rs; logic rco, rov; bit moved, rbad;
    run_op(16'h7FFF, 16'h0001, 1'b0, 1'b1, lat, rs, rco, rov, moved, rbad);
    checks++; if (rs !== 16'h8000 || rov !== 1'b1) begin
      errors++; $display("FAIL ovf_7fff got=%h/%b exp=8000/1", rs, rov);
    end
    run_op(16'h8000, 16'h8000, 1'b0, 1'b1, lat, rs, rco, rov, moved, rbad);
    checks++; if (rs !== 16'h0000 || rco !== 1'b1 || rov !== 1'b1) begin
      errors++; $display("FAIL ovf_8000 got=%h/%b/%b exp=0000/1/1", rs, rco, rov);
    end
    run_op(16'h1234, 16'h4321, 1'b0, 1'b1, lat, rs, rco, rov, moved, rbad);
    checks++; if (rov !== 1'b0) begin errors++; $display("FAIL ovf_none got=%b exp=0", rov); end
  endtask
`endif

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_abort();
    test_random();
    test_back_to_back();
`ifdef SIGNED_OVF_EN
    test_signed_ovf();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
